dram_bridge: RTL and testbench
==============================

# dram_bridge

Load/store bridge between the CPU core's memory port and the word-only `data_ram`. Accepts byte/halfword/word requests over a valid/ready handshake and formats loads with sign or zero extension. Performs sub-word stores as a registered read-modify-write, because `data_ram` has only a full-word `we`. Drives `data_ram`'s `a`/`we`/`d` and consumes its asynchronous `spo`.

## Interface
- `ADDR_BITS`, 16, word-address width to `data_ram`; must match its `ADDR_BITS`.
- `clk`  in  1  clock; `data_ram` shares it.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  core request valid.
- `req_ready`  out  1  bridge can accept; equals (state == IDLE) && !rst.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads: 1 = zero-extend, 0 = sign-extend; ignored for stores.
- `req_addr`  in  32  byte address; bits above `ADDR_BITS+1` ignored.
- `req_wdata`  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- `resp_valid`  out  1  response valid.
- `resp_ready`  in  1  core accepts response.
- `resp_rdata`  out  32  formatted load data; 0 for stores and errors.
- `resp_err`  out  1  request rejected; nothing was written.
- `ram_a`  out  ADDR_BITS  word address, `req_addr[ADDR_BITS+1:2]`, registered.
- `ram_we`  out  1  one-cycle write strobe.
- `ram_d`  out  32  write word.
- `ram_spo`  in  32  combinational read word from `data_ram`.

## Operation
- Little-endian lanes: byte offset o maps to bits [8o+7:8o]; a half at `addr[1]` = h maps to bits [16h+15:16h].
- FSM states are IDLE, ACCESS, MERGE, RESP. On a handshake in IDLE the bridge latches the request and `ram_a`.
- IDLE → ACCESS on handshake. IDLE → RESP directly, with `resp_err`=1, for size 11 or a misaligned access (see Configuration).
- ACCESS, load: capture lane from `ram_spo`, extend per `req_unsigned` into `resp_rdata`; → RESP.
- ACCESS, word store: `ram_we`=1, `ram_d`=`req_wdata`; → RESP.
- ACCESS, sub-word store: register merged word (`ram_spo` with the target lane(s) replaced by `req_wdata` low bits); → MERGE.
- MERGE: `ram_we`=1, `ram_d`=merged word; → RESP.
- RESP: `resp_valid`=1. Data and err are held stable until `resp_ready`; then → IDLE.
- `ram_we` is never high outside ACCESS(word store) or MERGE, and is never high while `rst`=1.

## Timing
- Handshake at edge 0. Load and word-store `resp_valid` rise after edge 2. Sub-word store `resp_valid` rises after edge 3. Error `resp_valid` rises after edge 1.
- Write lands in `data_ram` at the edge ending ACCESS (word store) or MERGE (sub-word store). A later load to the same word sees the new data.
- No new request is accepted until the RESP handshake completes. Single outstanding request.
- Reset values: state IDLE, `req_ready` 0 while `rst`=1 and 1 after. `resp_valid` 0, `resp_rdata` 0, `resp_err` 0, `ram_we` 0, `ram_a` 0, `ram_d` 0.
- Reset during ACCESS or MERGE aborts the request: no write occurs and no response is issued.

## Configuration
- `DRAM_BRIDGE_ALIGN_CHECK_EN` defined: a half with `addr[0]`=1, or a word with `addr[1:0]`≠0, gives `resp_err`=1 with no RAM access.
- Not defined: low address bits are ignored for alignment. A half uses `addr[1]`; a word ignores `addr[1:0]`. Only size 11 errors.

## Test plan
- Preload word 4 = 0x8899AABB. LB at 0x13, signed → `resp_rdata` 0xFFFFFF88, `resp_err` 0, `resp_valid` 2 cycles after handshake.
- LHU at 0x12 → 0x00008899. LH at 0x10 → 0xFFFFAABB.
- SB 0x0000005A at 0x11 → exactly one `ram_we` pulse with `ram_a`=4 and `ram_d`=0x88995ABB. `resp_valid` arrives 3 cycles after handshake. A following LW at 0x10 returns 0x88995ABB.
- SW 0x12345678 at 0x14, then LW at 0x14 → 0x12345678. Size 11 → `resp_err` 1 and no `ram_we`.
- LW at 0x12: with macro → `resp_err` 1, `resp_rdata` 0, no `ram_we`. Without macro → 0x8899AABB, `resp_err` 0.
- `resp_ready` held low for 5 cycles → `resp_valid`/`resp_rdata` stable and `req_ready` 0. Separately, `rst` pulsed in MERGE → no `ram_we`, word 4 unchanged, `req_ready` 1 the cycle after `rst` deasserts.

Source files
------------

// File: rtl/dram_bridge.sv
// Load/store bridge between the core memory port and the word-only data_ram.
// Latency: error 1 cycle, load / word store 2 cycles, sub-word store 3 cycles after the handshake.
// Backpressure: one request in flight; req_ready stays low until the response is taken.
//
// Ports:
//   clk, rst                 clock shared with data_ram; synchronous active-high reset
//   req_valid/req_ready      request handshake; req_we, req_size, req_unsigned,
//                            req_addr (byte address), req_wdata (right-aligned store data)
//   resp_valid/resp_ready    response handshake; resp_rdata (formatted load data), resp_err
//   ram_a, ram_we, ram_d     data_ram word address, write strobe, write word
//   ram_spo                  data_ram asynchronous read word
//
// Build option: define DRAM_BRIDGE_ALIGN_CHECK_EN to reject misaligned half/word accesses.
// Without it the low address bits are simply ignored for half/word alignment.
// ADDR_BITS must not exceed 30 (word address is taken from req_addr[ADDR_BITS+1:2]).

module dram_bridge #(
    parameter int ADDR_BITS = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_addr,
    input  logic [31:0]          req_wdata,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [31:0]          resp_rdata,
    output logic                 resp_err,
    output logic [ADDR_BITS-1:0] ram_a,
    output logic                 ram_we,
    output logic [31:0]          ram_d,
    input  logic [31:0]          ram_spo
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] MERGE  = 2'd2;
    localparam logic [1:0] RESP   = 2'd3;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_BAD  = 2'b11;

    // Request fields kept for the duration of the transaction.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [1:0]  off;
        logic [31:0] wdata;
    } op_t;

    logic [1:0] state;
    op_t        op;
    logic       req_bad;
    logic       op_word_store;

    // Address bits above the RAM window carry no meaning here.
    logic unused_addr_bits;
    assign unused_addr_bits = ^req_addr[31:ADDR_BITS+2];

    // Pick the addressed lane out of a RAM word and extend it to 32 bits.
    function automatic logic [31:0] fmt_load(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic        uns
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: res = {{24{~uns & b[7]}}, b};
            SZ_HALF: res = {{16{~uns & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

    // Replace the addressed byte or half of the current RAM word with store data.
    function automatic logic [31:0] merge_word(
        input logic [31:0] word,
        input logic [1:0]  size,
        input logic [1:0]  off,
        input logic [31:0] wd
    );
        logic [31:0] m;
        m = word;
        if (size == SZ_BYTE) begin
            case (off)
                2'd0:    m[7:0]   = wd[7:0];
                2'd1:    m[15:8]  = wd[7:0];
                2'd2:    m[23:16] = wd[7:0];
                default: m[31:24] = wd[7:0];
            endcase
        end else if (off[1]) begin
            m[31:16] = wd[15:0];
        end else begin
            m[15:0] = wd[15:0];
        end
        return m;
    endfunction

    // Requests that are answered with an error and never touch the RAM.
    always_comb begin
        req_bad = (req_size == SZ_BAD);
`ifdef DRAM_BRIDGE_ALIGN_CHECK_EN
        if ((req_size == SZ_HALF) && req_addr[0]) begin
            req_bad = 1'b1;
        end
        if ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00)) begin
            req_bad = 1'b1;
        end
`endif
    end

    assign op_word_store = op.we && (op.size == SZ_WORD);

    assign req_ready  = (state == IDLE) && !rst;
    assign resp_valid = (state == RESP);

    // Write strobe is decoded from state and gated by rst so that a reset
    // arriving in ACCESS or MERGE suppresses the pending write at that edge.
    assign ram_we = !rst && (((state == ACCESS) && op_word_store) || (state == MERGE));

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            op         <= '0;
            ram_a      <= '0;
            ram_d      <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op         <= '{we: req_we, size: req_size, uns: req_unsigned,
                                        off: req_addr[1:0], wdata: req_wdata};
                        ram_a      <= req_addr[ADDR_BITS+1:2];
                        resp_rdata <= '0;
                        resp_err   <= req_bad;
                        if (req_bad) begin
                            state <= RESP;
                        end else begin
                            state <= ACCESS;
                            // Word stores present their data straight away in ACCESS.
                            if (req_we && (req_size == SZ_WORD)) begin
                                ram_d <= req_wdata;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!op.we) begin
                        resp_rdata <= fmt_load(ram_spo, op.size, op.off, op.uns);
                        state      <= RESP;
                    end else if (op.size == SZ_WORD) begin
                        state <= RESP;
                    end else begin
                        // Read half of the read-modify-write: hold the merged word
                        // in ram_d so MERGE writes a registered value.
                        ram_d <= merge_word(ram_spo, op.size, op.off, op.wdata);
                        state <= MERGE;
                    end
                end
                MERGE: begin
                    state <= RESP;
                end
                default: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dram_bridge.sv
// Bench for dram_bridge with a word RAM, a byte-level reference memory and a response scoreboard.
// Latency: checks response timing against the handshake cycle of each request.
// Backpressure: response ready is withheld for random or fixed stretches.

module tb_dram_bridge;

    localparam int ADDR_BITS = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst;
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [1:0]           req_size;
    logic                 req_unsigned;
    logic [31:0]          req_addr;
    logic [31:0]          req_wdata;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [31:0]          resp_rdata;
    logic                 resp_err;
    logic [ADDR_BITS-1:0] ram_a;
    logic                 ram_we;
    logic [31:0]          ram_d;
    logic [31:0]          ram_spo;

    dram_bridge #(.ADDR_BITS(ADDR_BITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_ready   (resp_ready),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .ram_a        (ram_a),
        .ram_we       (ram_we),
        .ram_d        (ram_d),
        .ram_spo      (ram_spo)
    );

    // data_ram: asynchronous read, synchronous write; a side port preloads it.
    logic [31:0]          ram [0:65535];
    logic                 pl_we;
    logic [ADDR_BITS-1:0] pl_a;
    logic [31:0]          pl_d;

    assign ram_spo = ram[ram_a];

    always @(posedge clk) begin
        if (pl_we) begin
            ram[pl_a] <= pl_d;
        end else if (ram_we) begin
            ram[ram_a] <= ram_d;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: plain byte-addressed memory for the first 256 bytes.
    logic [7:0] ref_mem [0:255];

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  lat;
        logic        nwr;
        logic [15:0] wa;
        logic [31:0] wd;
    } exp_t;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } wr_t;

    exp_t exp_q[$];
    int   hs_q[$];
    wr_t  wr_q[$];

    int   checks = 0;
    int   failures = 0;
    int   stall_next = -1;
    logic busy = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h at cycle %0d", name, act, req, cyc);
        end
    endfunction

    function automatic void flag(input string name, input string msg);
        checks++;
        failures++;
        $display("FAIL %s %s at cycle %0d", name, msg, cyc);
    endfunction

    // Behavioural rules: byte/half/word view of a little-endian byte memory.
    function automatic exp_t model(input logic we, input logic [1:0] size, input logic uns,
                                   input logic [31:0] addr, input logic [31:0] wdata);
        exp_t        e;
        int          a, nb, base, wbase;
        logic [63:0] v;
        e = '0;
        a = int'(addr[7:0]);
        if (size == 2'b11) begin
            e.err = 1'b1;
            e.lat = 4'd1;
            return e;
        end
        nb   = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        base = a - (a % nb);
`ifdef DRAM_BRIDGE_ALIGN_CHECK_EN
        if (base != a) begin
            e.err = 1'b1;
            e.lat = 4'd1;
            return e;
        end
`endif
        if (we) begin
            for (int i = 0; i < nb; i++) ref_mem[base+i] = wdata[8*i +: 8];
            wbase = base - (base % 4);
            for (int i = 0; i < 4; i++) e.wd[8*i +: 8] = ref_mem[wbase+i];
            e.nwr = 1'b1;
            e.wa  = 16'(wbase / 4);
            e.lat = (nb == 4) ? 4'd2 : 4'd3;
        end else begin
            v = '0;
            for (int i = 0; i < nb; i++) v = v | (64'(ref_mem[base+i]) << (8*i));
            if (!uns && v[8*nb-1]) v = v - (64'd1 << (8*nb));
            e.rdata = v[31:0];
            e.lat   = 4'd2;
        end
        return e;
    endfunction

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata);
        int n;
        exp_q.push_back(model(we, size, uns, addr, wdata));
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            flag("req_accept", "req_ready never rose within 200 cycles");
            void'(exp_q.pop_back());
            req_valid = 1'b0;
            return;
        end
        hs_q.push_back(cyc);
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            flag("drain", "responses outstanding after 300 cycles");
            exp_q.delete();
            hs_q.delete();
        end
    endtask

    // Write monitor: every strobed cycle is a write into data_ram.
    initial begin : wr_monitor
        forever begin
            @(negedge clk);
            #1;
            if (ram_we) begin
                if (rst) flag("we_in_reset", "ram_we high while rst is high");
                wr_q.push_back('{a: ram_a, d: ram_d});
            end
        end
    end

    // Response monitor: pops the scoreboard and drives resp_ready.
    initial begin : resp_monitor
        exp_t e;
        wr_t  w;
        int   hs;
        int   stall;
        resp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && resp_valid) begin
                busy = 1'b1;
                if (exp_q.size() == 0 || hs_q.size() == 0) begin
                    flag("resp_unexpected", "response with empty scoreboard");
                    wr_q.delete();
                end else begin
                    e  = exp_q.pop_front();
                    hs = hs_q.pop_front();
                    chk("resp_rdata", resp_rdata, e.rdata);
                    chk("resp_err", 32'(resp_err), 32'(e.err));
                    chk("resp_latency", 32'(cyc - hs), 32'(e.lat));
                    chk("req_ready_in_resp", 32'(req_ready), 32'd0);
                    chk("write_count", 32'(wr_q.size()), 32'(e.nwr));
                    if (e.nwr && wr_q.size() == 1) begin
                        w = wr_q.pop_front();
                        chk("write_addr", 32'(w.a), 32'(e.wa));
                        chk("write_data", w.d, e.wd);
                    end
                    wr_q.delete();
                    if (stall_next >= 0) begin
                        stall = stall_next;
                        stall_next = -1;
                    end else begin
                        stall = $urandom_range(0, 2);
                    end
                    for (int k = 0; k < stall; k++) begin
                        @(negedge clk);
                        chk("hold_valid", 32'(resp_valid), 32'd1);
                        chk("hold_rdata", resp_rdata, e.rdata);
                        chk("hold_err", 32'(resp_err), 32'(e.err));
                        chk("hold_req_ready", 32'(req_ready), 32'd0);
                    end
                end
                resp_ready = 1'b1;
                @(negedge clk);
                resp_ready = 1'b0;
                busy = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        flag("watchdog", "simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [31:0] d, r, hi, av;
        logic [1:0]  sz;
        int          n;
        rst          = 1'b1;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = '0;
        pl_we        = 1'b0;
        pl_a         = '0;
        pl_d         = '0;

        repeat (3) @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd0);
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_ram_we", 32'(ram_we), 32'd0);
        chk("reset_resp_rdata", resp_rdata, 32'd0);
        chk("reset_resp_err", 32'(resp_err), 32'd0);
        chk("reset_ram_a", 32'(ram_a), 32'd0);
        chk("reset_ram_d", ram_d, 32'd0);

        // Preload words 0..63 while held in reset; word 4 gets the known pattern.
        for (int w = 0; w < 64; w++) begin
            d = (w == 4) ? 32'h8899AABB : $urandom;
            for (int i = 0; i < 4; i++) ref_mem[4*w+i] = d[8*i +: 8];
            pl_we = 1'b1;
            pl_a  = 16'(w);
            pl_d  = d;
            @(negedge clk);
        end
        pl_we = 1'b0;

        rst = 1'b0;
        #1;
        chk("post_reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);

        // Directed loads on word 4.
        issue(1'b0, 2'b00, 1'b0, 32'h0000_0013, 32'h0);
        drain();
        issue(1'b0, 2'b01, 1'b1, 32'h0000_0012, 32'h0);
        drain();
        issue(1'b0, 2'b01, 1'b0, 32'h0000_0010, 32'h0);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0012, 32'h0);
        drain();

        // Sub-word store, then read back; word store, then read back.
        issue(1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_005A);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0);
        drain();
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0014, 32'h1234_5678);
        drain();
        issue(1'b0, 2'b10, 1'b0, 32'h0000_0014, 32'h0);
        drain();

        // Illegal size, load and store flavours.
        issue(1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0);
        drain();
        issue(1'b1, 2'b11, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF);
        drain();

        // Response held off for five extra cycles.
        stall_next = 5;
        issue(1'b0, 2'b00, 1'b1, 32'h0000_0012, 32'h0);
        drain();

        // Reset asserted during MERGE of a sub-word store aborts it.
        req_we       = 1'b1;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        req_addr     = 32'h0000_0011;
        req_wdata    = 32'h0000_00EE;
        req_valid    = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_ram_we", 32'(ram_we), 32'd0);
        chk("abort_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_req_ready_after", 32'(req_ready), 32'd1);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_write_count", 32'(wr_q.size()), 32'd0);
        chk("abort_word4", ram[4], {ref_mem[19], ref_mem[18], ref_mem[17], ref_mem[16]});
        wr_q.delete();

        // Randomized traffic; high address bits are junk the bridge must ignore.
        for (int t = 0; t < 300; t++) begin
            r  = $urandom;
            hi = $urandom;
            av = 32'($urandom_range(0, 255));
            sz = r[3:2];
            if (sz == 2'b11) sz = 2'b10;
            if (r[6:4] == 3'd0) sz = 2'b11;
            if (r[7]) repeat (int'(r[9:8])) @(negedge clk);
            issue(r[0], sz, r[1], {hi[31:18], 10'd0, av[7:0]}, $urandom);
        end
        drain();

        for (int w = 0; w < 64; w++) begin
            chk("final_ram_word", ram[w],
                {ref_mem[4*w+3], ref_mem[4*w+2], ref_mem[4*w+1], ref_mem[4*w]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
